// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - splits 32-bit fetch words into 16/32-bit instruction parcels
// Holds one leftover halfword so that compressed and spanning 32-bit instructions are emitted in order.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] fetch_addr,
    input  logic [31:0] fetch_data,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_SKIP  = 2'd2;

    logic [1:0]  state;
    logic [15:0] hbuf;
    logic [31:0] hpc;

    logic        low_is_c;
    logic        hbuf_is_c;
    logic        xfer;
    logic [31:0] next_word_addr;
    logic [31:0] upper_pc;

    assign low_is_c       = (fetch_data[1:0] != 2'b11);
    assign hbuf_is_c      = (hbuf[1:0] != 2'b11);
    assign xfer           = inst_valid & inst_ready;
    assign next_word_addr = fetch_addr + 32'd4;
    assign upper_pc       = fetch_addr + 32'd2;

    always_comb begin
        inst        = 32'h0;
        inst_pc     = fetch_addr;
        inst_valid  = 1'b0;
        fetch_ready = 1'b0;
        case (state)
            ST_EMPTY: begin
                inst        = low_is_c ? {16'h0, fetch_data[15:0]} : fetch_data;
                inst_pc     = fetch_addr;
                inst_valid  = fetch_valid;
                fetch_ready = inst_ready & fetch_valid;
            end
            ST_HALF: begin
                inst_pc = hpc;
                if (hbuf_is_c) begin
                    // Buffered compressed parcel needs no memory word.
                    inst        = {16'h0, hbuf};
                    inst_valid  = 1'b1;
                    fetch_ready = 1'b0;
                end else begin
                    inst        = {fetch_data[15:0], hbuf};
                    inst_valid  = fetch_valid;
                    fetch_ready = inst_ready & fetch_valid;
                end
            end
            ST_SKIP: begin
                inst_valid  = 1'b0;
                fetch_ready = fetch_valid;
            end
            default: begin
                inst_valid  = 1'b0;
                fetch_ready = 1'b0;
            end
        endcase
        if (flush) begin
            inst_valid  = 1'b0;
            fetch_ready = 1'b0;
        end
    end

    assign inst_is_c = (inst[1:0] != 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            hbuf       <= 16'h0;
            hpc        <= 32'h0;
            fetch_addr <= RESET_PC;
        end else if (flush) begin
            fetch_addr <= {flush_pc[31:2], 2'b00};
            state      <= flush_pc[1] ? ST_SKIP : ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer) begin
                        fetch_addr <= next_word_addr;
                        if (low_is_c) begin
                            hbuf  <= fetch_data[31:16];
                            hpc   <= upper_pc;
                            state <= ST_HALF;
                        end
                    end
                end
                ST_HALF: begin
                    if (xfer) begin
                        if (hbuf_is_c) begin
                            state <= ST_EMPTY;
                        end else begin
                            hbuf       <= fetch_data[31:16];
                            hpc        <= upper_pc;
                            fetch_addr <= next_word_addr;
                        end
                    end
                end
                ST_SKIP: begin
                    // Lower halfword lies before the redirect target and is dropped.
                    if (fetch_valid) begin
                        hbuf       <= fetch_data[31:16];
                        hpc        <= upper_pc;
                        fetch_addr <= next_word_addr;
                        state      <= ST_HALF;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - directed scoreboard bench for fetch_aligner
// Stimulus pushes expected parcels; a negedge monitor pops them on every transfer.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;

    logic [31:0] mem [0:255];
    logic [64:0] exp_q [$];
    int          checks = 0;
    int          fails = 0;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_is_c  (inst_is_c),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .flush      (flush),
        .flush_pc   (flush_pc)
    );

    always #5 clk = ~clk;

    assign fetch_data = mem[fetch_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] pc, input logic c);
        exp_q.push_back({i, pc, c});
    endtask

    task automatic drive(input logic fv, input logic ir, input logic fl, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        fetch_valid = fv;
        inst_ready  = ir;
        flush       = fl;
        flush_pc    = fpc;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        inst_ready  = 1'b0;
        flush       = 1'b0;
        #1;
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h0);
        chk("rst_fetch_addr", fetch_addr, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_xfer: got inst %h pc %h, expected no transfer", inst, inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("mon_inst", inst, e[64:33]);
                chk("mon_pc", inst_pc, e[32:1]);
                chk("mon_is_c", {31'h0, inst_is_c}, {31'h0, e[0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;

        // Plain 32-bit instruction at reset address
        mem[0] = 32'h0041_0513;
        mem[1] = 32'h0000_0013;
        do_reset();
        push(32'h0041_0513, 32'h0, 1'b0);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("a_fetch_ready", {31'h0, fetch_ready}, 32'h1);
        chk("a_fetch_addr0", fetch_addr, 32'h0);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("a_fetch_addr4", fetch_addr, 32'h4);
        chk("a_idle_valid", {31'h0, inst_valid}, 32'h0);

        // Two compressed parcels in one word
        mem[0] = 32'h4108_0505;
        do_reset();
        push(32'h0000_0505, 32'h0, 1'b1);
        push(32'h0000_4108, 32'h2, 1'b1);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("b_ready_c1", {31'h0, fetch_ready}, 32'h1);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("b_ready_c2", {31'h0, fetch_ready}, 32'h0);
        chk("b_valid_c2", {31'h0, inst_valid}, 32'h1);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("b_empty_valid", {31'h0, inst_valid}, 32'h0);
        chk("b_fetch_addr", fetch_addr, 32'h4);

        // Spanning instruction with a 3-cycle downstream stall
        mem[0] = 32'h0513_0505;
        mem[1] = 32'hABCD_0041;
        do_reset();
        push(32'h0000_0505, 32'h0, 1'b1);
        push(32'h0041_0513, 32'h2, 1'b0);
        push(32'h0000_ABCD, 32'h6, 1'b1);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("c_ready0", {31'h0, fetch_ready}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            @(negedge clk);
            chk("c_stall_ready", {31'h0, fetch_ready}, 32'h0);
            chk("c_stall_inst", inst, 32'h0041_0513);
            chk("c_stall_addr", fetch_addr, 32'h4);
        end
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("c_span_ready", {31'h0, fetch_ready}, 32'h1);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("c_hbuf_valid", {31'h0, inst_valid}, 32'h1);
        chk("c_hbuf_ready", {31'h0, fetch_ready}, 32'h0);
        chk("c_hbuf_inst", inst, 32'h0000_ABCD);
        chk("c_fetch_addr", fetch_addr, 32'h8);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("c_empty_valid", {31'h0, inst_valid}, 32'h0);

        // Flush to a halfword-aligned target
        mem[0]  = 32'h4108_0505;
        mem[64] = 32'h4509_1234;
        do_reset();
        drive(1, 1, 1, 32'h0000_0102);
        @(negedge clk);
        chk("d_flush_valid", {31'h0, inst_valid}, 32'h0);
        chk("d_flush_ready", {31'h0, fetch_ready}, 32'h0);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("d_skip_addr", fetch_addr, 32'h100);
        chk("d_skip_valid", {31'h0, inst_valid}, 32'h0);
        chk("d_skip_ready", {31'h0, fetch_ready}, 32'h1);
        push(32'h0000_4509, 32'h102, 1'b1);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("d_after_addr", fetch_addr, 32'h104);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("d_empty_valid", {31'h0, inst_valid}, 32'h0);

        // Asynchronous reset while holding a halfword
        do_reset();
        push(32'h0000_0505, 32'h0, 1'b1);
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("e_half_valid", {31'h0, inst_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("e_arst_valid", {31'h0, inst_valid}, 32'h0);
        chk("e_arst_ready", {31'h0, fetch_ready}, 32'h0);
        chk("e_arst_addr", fetch_addr, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("e_discard_valid", {31'h0, inst_valid}, 32'h0);

        // Address wrap at the top of memory
        mem[255] = 32'h0000_0013;
        drive(0, 1, 1, 32'hFFFF_FFFC);
        push(32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("f_top_addr", fetch_addr, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("f_wrap_addr", fetch_addr, 32'h0);

        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
